// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX-resolved redirects and data-memory waits,
// with stall/redirect performance counters and a sticky memory-timeout flag.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ex_MemRead,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             ex_branch_valid,
   input  logic             ex_branch_taken,
   input  logic             ex_pred_taken,
   input  logic             id_ex_Jr,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             hazard_pcStall,
   output logic             hazard_pcFromTaken,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_stall,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, SHADOW, MEM_WAIT} state_t;

   localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

   state_t      state;
   logic [15:0] wait_cnt;
   logic [15:0] wait_cnt_inc;

   logic memwait;
   logic mispredict;
   logic loaduse;
   logic redirect;
   logic bubble;

   always_comb begin
      memwait  = mem_req & ~mem_ready;
      // EX holds a flushed bubble in SHADOW, so its branch/jr signals are stale there.
      mispredict = (state != SHADOW) &
                   ((ex_branch_valid & (ex_branch_taken != ex_pred_taken)) | id_ex_Jr);
      loaduse  = id_ex_MemRead & (id_ex_rt != 5'd0) &
                 ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));
      redirect = ~memwait & mispredict;
      bubble   = ~memwait & ~mispredict & loaduse;
      wait_cnt_inc = (wait_cnt >= TIMEOUT) ? TIMEOUT : wait_cnt + 16'd1;
   end

   assign hazard_pcStall     = ~reset & (memwait | bubble);
   assign hazard_pcFromTaken = ~reset & redirect;
   assign if_id_stall        = ~reset & (memwait | bubble);
   assign if_id_flush        = ~reset & redirect;
   assign id_ex_flush        = ~reset & (redirect | bubble);
   assign pipe_stall         = ~reset & memwait;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         wait_cnt    <= 16'd0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         if (hazard_pcStall)
            stall_cnt <= stall_cnt + 1'b1;
         if (memwait) begin
            state    <= MEM_WAIT;
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT)
               mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= 16'd0;
            if (redirect) begin
               state     <= SHADOW;
               flush_cnt <= flush_cnt + 1'b1;
            end else begin
               state <= RUN;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, redirects, SHADOW masking, memory waits,
// timeout stickiness and asynchronous reset in the middle of a wait.
module tb_hazard_ctrl;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             id_ex_MemRead;
   logic [4:0]       id_ex_rt;
   logic [4:0]       if_id_rs;
   logic [4:0]       if_id_rt;
   logic             if_id_uses_rt;
   logic             ex_branch_valid;
   logic             ex_branch_taken;
   logic             ex_pred_taken;
   logic             id_ex_Jr;
   logic             mem_req;
   logic             mem_ready;
   logic             hazard_pcStall;
   logic             hazard_pcFromTaken;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             pipe_stall;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_ctrl #(.MEM_TIMEOUT(5), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .id_ex_MemRead      (id_ex_MemRead),
      .id_ex_rt           (id_ex_rt),
      .if_id_rs           (if_id_rs),
      .if_id_rt           (if_id_rt),
      .if_id_uses_rt      (if_id_uses_rt),
      .ex_branch_valid    (ex_branch_valid),
      .ex_branch_taken    (ex_branch_taken),
      .ex_pred_taken      (ex_pred_taken),
      .id_ex_Jr           (id_ex_Jr),
      .mem_req            (mem_req),
      .mem_ready          (mem_ready),
      .hazard_pcStall     (hazard_pcStall),
      .hazard_pcFromTaken (hazard_pcFromTaken),
      .if_id_stall        (if_id_stall),
      .if_id_flush        (if_id_flush),
      .id_ex_flush        (id_ex_flush),
      .pipe_stall         (pipe_stall),
      .mem_timeout        (mem_timeout),
      .stall_cnt          (stall_cnt),
      .flush_cnt          (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Control vector order: {pcStall, pcFromTaken, if_id_stall, if_id_flush, id_ex_flush, pipe_stall}
   task automatic check_ctl(input string tag, input logic [5:0] exp);
      check(tag, {26'd0, hazard_pcStall, hazard_pcFromTaken, if_id_stall,
                  if_id_flush, id_ex_flush, pipe_stall}, {26'd0, exp});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_ex_MemRead = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0; if_id_uses_rt = 0;
      ex_branch_valid = 0; ex_branch_taken = 0; ex_pred_taken = 0; id_ex_Jr = 0;
      mem_req = 0; mem_ready = 0;
   endtask

   task automatic set_loaduse(input logic [4:0] rt);
      id_ex_MemRead = 1; id_ex_rt = rt; if_id_rs = rt;
   endtask

   task automatic set_mispredict();
      ex_branch_valid = 1; ex_branch_taken = 0; ex_pred_taken = 1;
   endtask

   initial begin
      idle();
      reset = 1;
      #1;
      check_ctl("rst_ctl", 6'b000000);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      check("rst_timeout", {31'd0, mem_timeout}, 0);
      cyc();
      cyc();
      reset = 0;
      cyc();

      // Load-use on rs
      set_loaduse(5'd8);
      #1 check_ctl("lu_rs", 6'b101010);
      cyc();
      idle();
      #1 check_ctl("lu_after", 6'b000000);
      check("lu_stall_cnt", stall_cnt, 1);
      // Load into $0 never stalls
      set_loaduse(5'd0);
      #1 check_ctl("lu_r0", 6'b000000);
      cyc();
      idle();
      // Load-use on rt, with and without uses_rt
      id_ex_MemRead = 1; id_ex_rt = 9; if_id_rt = 9; if_id_rs = 3; if_id_uses_rt = 1;
      #1 check_ctl("lu_rt", 6'b101010);
      if_id_uses_rt = 0;
      #1 check_ctl("lu_rt_unused", 6'b000000);
      if_id_uses_rt = 1;
      cyc();
      idle();
      check("lu_rt_cnt", stall_cnt, 2);

      // Branch mispredict, then SHADOW ignores a repeated mismatch but still sees load-use
      set_mispredict();
      #1 check_ctl("mp_redirect", 6'b010110);
      cyc();
      check("mp_flush_cnt", flush_cnt, 1);
      #1 check_ctl("mp_shadow", 6'b000000);
      set_loaduse(5'd8);
      #1 check_ctl("shadow_lu", 6'b101010);
      cyc();
      idle();
      check("shadow_lu_cnt", stall_cnt, 3);
      check("shadow_flush", flush_cnt, 1);

      // jr with simultaneous load-use: redirect only
      id_ex_Jr = 1;
      set_loaduse(5'd8);
      #1 check_ctl("jr_lu", 6'b010110);
      cyc();
      idle();
      check("jr_flush_cnt", flush_cnt, 2);
      check("jr_stall_cnt", stall_cnt, 3);
      cyc();

      // Memory wait deferring a mispredict
      mem_req = 1; mem_ready = 0;
      set_mispredict();
      for (int i = 0; i < 4; i++) begin
         #1 check_ctl($sformatf("mw_%0d", i), 6'b101001);
         cyc();
      end
      check("mw_stall_cnt", stall_cnt, 7);
      mem_ready = 1;
      #1 check_ctl("mw_release", 6'b010110);
      cyc();
      idle();
      check("mw_flush_cnt", flush_cnt, 3);
      check("mw_timeout", {31'd0, mem_timeout}, 0);
      cyc();

      // Timeout after the 5th wait cycle, sticky afterwards
      mem_req = 1; mem_ready = 0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         check($sformatf("to_%0d", k), {31'd0, mem_timeout}, (k >= 5) ? 32'd1 : 32'd0);
      end
      check("to_stall_cnt", stall_cnt, 15);
      mem_ready = 1;
      cyc();
      idle();
      cyc();
      check("to_sticky", {31'd0, mem_timeout}, 1);

      // Asynchronous reset in the middle of a memory wait
      mem_req = 1; mem_ready = 0;
      set_mispredict();
      for (int k = 0; k < 10; k++) cyc();
      #2 reset = 1;
      #1 check_ctl("arst_ctl", 6'b000000);
      check("arst_stall_cnt", stall_cnt, 0);
      check("arst_flush_cnt", flush_cnt, 0);
      check("arst_timeout", {31'd0, mem_timeout}, 0);
      cyc();
      reset = 0;
      idle();
      cyc();
      set_mispredict();
      #1 check_ctl("post_rst_run", 6'b010110);
      cyc();
      idle();
      check("post_rst_flush", flush_cnt, 1);
      check("post_rst_to", {31'd0, mem_timeout}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
